// File: rtl/fpa_mant_engine.sv
// Signed fractional mantissa engine: add, subtract, normalize and Booth radix-2 multiply,
// sequenced internally behind a start/busy/done handshake. Sign is the MSB of each vector.
module fpa_mant_engine #(
    parameter int unsigned MW = 40,
    parameter int unsigned EW = 8
) (
    input  logic          clk_sys,
    input  logic          clr_,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [MW-1:0] a,
    input  logic [MW-1:0] b,
    input  logic [EW-1:0] ea,
    output logic          busy,
    output logic          done,
    output logic [MW-1:0] r_hi,
    output logic [MW-1:0] r_lo,
    output logic [EW-1:0] er,
    output logic          z,
    output logic          v
);

    localparam int unsigned CW = $clog2(MW + 1);
    localparam logic [1:0] OP_MUL = 2'b11;
    localparam logic [EW-1:0] EXP_MAX = {1'b0, {(EW - 1){1'b1}}};
    localparam logic [EW-1:0] EXP_MIN = {1'b1, {(EW - 1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_NORM,
        S_MUL,
        S_DONE
    } state_t;

    state_t        state;
    logic [1:0]    op_r;
    logic [MW:0]   t_r;
    logic [MW-1:0] m_r;
    logic          m1_r;
    logic [MW-1:0] c_r;
    logic [CW-1:0] cnt_r;
    logic [EW-1:0] exp_r;

    logic [MW:0]     c_ext;
    logic [MW:0]     addsub;
    logic            as_ovf;
    logic            need_shift;
    logic            norm_uf;
    logic            at_bound;
    logic [MW:0]     booth_sum;
    logic [MW:0]     t_nx;
    logic [MW-1:0]   m_nx;
    logic [2*MW-1:0] prod;
    logic            mul_sat;
    logic            finish;
    logic [MW-1:0]   fin_hi;
    logic [MW-1:0]   fin_lo;
    logic [EW-1:0]   fin_er;
    logic            fin_v;

    // Datapath and the result that would be written if this cycle ends the operation
    always_comb begin
        c_ext      = {c_r[MW-1], c_r};
        addsub     = op_r[0] ? (t_r - c_ext) : (t_r + c_ext);
        as_ovf     = addsub[MW] ^ addsub[MW-1];
        need_shift = (t_r[MW-1] == t_r[MW-2]);
        norm_uf    = need_shift && (exp_r == EXP_MIN);
        at_bound   = (cnt_r == CW'(MW - 1));
        case ({m_r[0], m1_r})
            2'b01:   booth_sum = t_r + c_ext;
            2'b10:   booth_sum = t_r - c_ext;
            default: booth_sum = t_r;
        endcase
        t_nx    = {booth_sum[MW], booth_sum[MW:1]};
        m_nx    = {booth_sum[0], m_r[MW-1:1]};
        prod    = {t_nx[MW-1:0], m_nx};
        // Only -1.0 * -1.0 leaves the doubled product unrepresentable
        mul_sat = prod[2*MW-1] ^ prod[2*MW-2];

        finish = 1'b0;
        fin_hi = '0;
        fin_lo = '0;
        fin_er = '0;
        fin_v  = 1'b0;
        case (state)
            S_EXEC: begin
                if (!op_r[1]) begin
                    finish = 1'b1;
                    fin_hi = as_ovf ? addsub[MW:1] : addsub[MW-1:0];
                    if (!as_ovf) begin
                        fin_er = exp_r;
                    end else if (exp_r == EXP_MAX) begin
                        fin_er = EXP_MAX;
                        fin_v  = 1'b1;
                    end else begin
                        fin_er = exp_r + EW'(1);
                    end
                end else if (t_r[MW-1:0] == '0) begin
                    finish = 1'b1;
                end else if (norm_uf) begin
                    finish = 1'b1;
                    fin_v  = 1'b1;
                end else if (!need_shift) begin
                    finish = 1'b1;
                    fin_hi = t_r[MW-1:0];
                    fin_er = exp_r;
                end
            end
            S_NORM: begin
                if (!need_shift || at_bound) begin
                    finish = 1'b1;
                    fin_hi = t_r[MW-1:0];
                    fin_er = exp_r;
                end else if (norm_uf) begin
                    finish = 1'b1;
                    fin_v  = 1'b1;
                end
            end
            S_MUL: begin
                if (at_bound) begin
                    finish = 1'b1;
                    fin_er = exp_r;
                    if (mul_sat) begin
                        fin_hi = {1'b0, {(MW - 1){1'b1}}};
                        fin_lo = '1;
                        fin_v  = 1'b1;
                    end else begin
                        fin_hi = prod[2*MW-2:MW-1];
                        fin_lo = {prod[MW-2:0], 1'b0};
                    end
                end
            end
            default: ;
        endcase
    end

    // Sequencer, operand registers and registered result outputs
    always_ff @(posedge clk_sys or negedge clr_) begin
        if (!clr_) begin
            state <= S_IDLE;
            op_r  <= '0;
            t_r   <= '0;
            m_r   <= '0;
            m1_r  <= 1'b0;
            c_r   <= '0;
            cnt_r <= '0;
            exp_r <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            r_hi  <= '0;
            r_lo  <= '0;
            er    <= '0;
            z     <= 1'b0;
            v     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_r  <= op;
                        exp_r <= ea;
                        cnt_r <= '0;
                        m1_r  <= 1'b0;
                        busy  <= 1'b1;
                        if (op == OP_MUL) begin
                            t_r   <= '0;
                            m_r   <= b;
                            c_r   <= a;
                            state <= S_MUL;
                        end else begin
                            t_r   <= {a[MW-1], a};
                            m_r   <= '0;
                            c_r   <= b;
                            state <= S_EXEC;
                        end
                    end
                end
                S_EXEC, S_NORM: begin
                    if (!finish) begin
                        t_r   <= {t_r[MW-1:0], 1'b0};
                        exp_r <= exp_r - EW'(1);
                        cnt_r <= cnt_r + CW'(1);
                        state <= S_NORM;
                    end
                end
                S_MUL: begin
                    t_r   <= t_nx;
                    m_r   <= m_nx;
                    m1_r  <= m_r[0];
                    cnt_r <= cnt_r + CW'(1);
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            if (finish) begin
                r_hi  <= fin_hi;
                r_lo  <= fin_lo;
                er    <= fin_er;
                v     <= fin_v;
                z     <= (fin_hi == '0) && (fin_lo == '0);
                done  <= 1'b1;
                state <= S_DONE;
            end
        end
    end

endmodule

// File: tb/tb_fpa_mant_engine.sv
// Directed bench for fpa_mant_engine: an 8-bit instance for the arithmetic and handshake
// vectors, a 40-bit instance for the mid-multiply reset scenario.
module tb_fpa_mant_engine;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_NORM = 2'b10;
    localparam logic [1:0] OP_MUL  = 2'b11;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;

    logic       clr8, s8, busy8, done8, z8, v8;
    logic [1:0] op8;
    logic [7:0] a8, b8, ea8, hi8, lo8, er8;

    logic        clr40, s40, busy40, done40, z40, v40;
    logic [1:0]  op40;
    logic [39:0] a40, b40, hi40, lo40;
    logic [7:0]  ea40, er40;

    fpa_mant_engine #(.MW(8), .EW(8)) u8 (
        .clk_sys(clk_sys), .clr_(clr8), .start(s8), .op(op8), .a(a8), .b(b8), .ea(ea8),
        .busy(busy8), .done(done8), .r_hi(hi8), .r_lo(lo8), .er(er8), .z(z8), .v(v8)
    );

    fpa_mant_engine #(.MW(40), .EW(8)) u40 (
        .clk_sys(clk_sys), .clr_(clr40), .start(s40), .op(op40), .a(a40), .b(b40), .ea(ea40),
        .busy(busy40), .done(done40), .r_hi(hi40), .r_lo(lo40), .er(er40), .z(z40), .v(v40)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge; returns edges from the sampling edge to done
    task automatic run8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ea, output int l);
        s8 = 1'b1; op8 = op; a8 = a; b8 = b; ea8 = ea;
        @(posedge clk_sys); #1;
        s8 = 1'b0;
        l = 1;
        while (done8 !== 1'b1 && l < 200) begin
            @(posedge clk_sys); #1;
            l++;
        end
    endtask

    task automatic run40(input logic [1:0] op, input logic [39:0] a, input logic [39:0] b,
                         input logic [7:0] ea, output int l);
        s40 = 1'b1; op40 = op; a40 = a; b40 = b; ea40 = ea;
        @(posedge clk_sys); #1;
        s40 = 1'b0;
        l = 1;
        while (done40 !== 1'b1 && l < 200) begin
            @(posedge clk_sys); #1;
            l++;
        end
    endtask

    initial begin
        clr8 = 1'b0; s8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; ea8 = '0;
        clr40 = 1'b0; s40 = 1'b0; op40 = '0; a40 = '0; b40 = '0; ea40 = '0;
        repeat (2) @(posedge clk_sys);
        #1;
        chk("rst_busy", 64'(busy8), 64'd0);
        chk("rst_done", 64'(done8), 64'd0);
        chk("rst_res", 64'({hi8, lo8, er8, z8, v8}), 64'd0);
        clr8 = 1'b1; clr40 = 1'b1;
        @(posedge clk_sys); #1;

        run8(OP_ADD, 8'h40, 8'h40, 8'd3, lat);
        chk("add_ovf_lat", 64'(lat), 64'd2);
        chk("add_ovf_hi", 64'(hi8), 64'h40);
        chk("add_ovf_lo", 64'(lo8), 64'h00);
        chk("add_ovf_er", 64'(er8), 64'h04);
        chk("add_ovf_v", 64'(v8), 64'd0);
        @(posedge clk_sys); #1;

        run8(OP_ADD, 8'h40, 8'h40, 8'h7F, lat);
        chk("add_sat_hi", 64'(hi8), 64'h40);
        chk("add_sat_er", 64'(er8), 64'h7F);
        chk("add_sat_v", 64'(v8), 64'd1);
        @(posedge clk_sys); #1;

        run8(OP_NORM, 8'h03, 8'h00, 8'h00, lat);
        chk("norm3_lat", 64'(lat), 64'd7);
        chk("norm3_hi", 64'(hi8), 64'h60);
        chk("norm3_er", 64'(er8), 64'hFB);
        chk("norm3_v", 64'(v8), 64'd0);
        @(posedge clk_sys); #1;

        run8(OP_NORM, 8'h00, 8'h00, 8'h05, lat);
        chk("norm0_lat", 64'(lat), 64'd2);
        chk("norm0_hi", 64'(hi8), 64'h00);
        chk("norm0_z", 64'(z8), 64'd1);
        chk("norm0_er", 64'(er8), 64'h00);
        @(posedge clk_sys); #1;

        run8(OP_NORM, 8'h01, 8'h00, 8'h81, lat);
        chk("norm_uf_lat", 64'(lat), 64'd3);
        chk("norm_uf_zv", 64'({z8, v8}), 64'b11);
        chk("norm_uf_er", 64'(er8), 64'h00);
        chk("norm_uf_hi", 64'(hi8), 64'h00);
        @(posedge clk_sys); #1;

        run8(OP_NORM, 8'h80, 8'h00, 8'h05, lat);
        chk("norm_m1_lat", 64'(lat), 64'd2);
        chk("norm_m1_hi", 64'(hi8), 64'h80);
        chk("norm_m1_er", 64'(er8), 64'h05);
        chk("norm_m1_zv", 64'({z8, v8}), 64'b00);
        @(posedge clk_sys); #1;

        run8(OP_MUL, 8'h40, 8'hC0, 8'h02, lat);
        chk("mul_lat", 64'(lat), 64'd9);
        chk("mul_hi", 64'(hi8), 64'hE0);
        chk("mul_lo", 64'(lo8), 64'h00);
        chk("mul_er", 64'(er8), 64'h02);
        chk("mul_v", 64'(v8), 64'd0);
        @(posedge clk_sys); #1;

        run8(OP_MUL, 8'h80, 8'h80, 8'h01, lat);
        chk("mul_sat_hi", 64'(hi8), 64'h7F);
        chk("mul_sat_lo", 64'(lo8), 64'hFF);
        chk("mul_sat_v", 64'(v8), 64'd1);
        @(posedge clk_sys); #1;

        run8(OP_SUB, 8'h80, 8'h01, 8'h02, lat);
        chk("sub_ovf_hi", 64'(hi8), 64'hBF);
        chk("sub_ovf_er", 64'(er8), 64'h03);
        chk("sub_ovf_v", 64'(v8), 64'd0);
        @(posedge clk_sys); #1;

        run8(OP_SUB, 8'h10, 8'h10, 8'h06, lat);
        chk("sub_zero_hi", 64'(hi8), 64'h00);
        chk("sub_zero_z", 64'(z8), 64'd1);
        chk("sub_zero_er", 64'(er8), 64'h06);
        @(posedge clk_sys); #1;

        // start held high for the whole multiply, including the done cycle
        s8 = 1'b1; op8 = OP_MUL; a8 = 8'h40; b8 = 8'h40; ea8 = 8'h00;
        @(posedge clk_sys); #1;
        lat = 1;
        while (done8 !== 1'b1 && lat < 200) begin
            @(posedge clk_sys); #1;
            lat++;
        end
        chk("held_lat", 64'(lat), 64'd9);
        chk("held_hi", 64'(hi8), 64'h20);
        chk("held_busy_done", 64'(busy8), 64'd1);
        @(posedge clk_sys); #1;
        chk("held_idle_busy", 64'({busy8, done8}), 64'b00);
        s8 = 1'b0;
        @(posedge clk_sys); #1;
        chk("held_no_rerun", 64'(busy8), 64'd0);
        chk("held_result_kept", 64'(hi8), 64'h20);

        // start pulsed only in the done cycle must not be queued
        run8(OP_ADD, 8'h20, 8'h10, 8'h00, lat);
        s8 = 1'b1; op8 = OP_ADD; a8 = 8'h08; b8 = 8'h08; ea8 = 8'h01;
        @(posedge clk_sys); #1;
        s8 = 1'b0;
        chk("pulse_done_ign", 64'({busy8, done8}), 64'b00);
        @(posedge clk_sys); #1;
        chk("pulse_not_queued", 64'(busy8), 64'd0);
        chk("pulse_result_kept", 64'(hi8), 64'h30);

        // start on the cycle after done is accepted
        run8(OP_ADD, 8'h20, 8'h10, 8'h00, lat);
        s8 = 1'b1; op8 = OP_ADD; a8 = 8'h08; b8 = 8'h08; ea8 = 8'h01;
        @(posedge clk_sys); #1;
        chk("after_done_ign", 64'(busy8), 64'd0);
        @(posedge clk_sys); #1;
        s8 = 1'b0;
        chk("after_accept", 64'(busy8), 64'd1);
        chk("after_hold_hi", 64'(hi8), 64'h30);
        lat = 1;
        while (done8 !== 1'b1 && lat < 200) begin
            @(posedge clk_sys); #1;
            lat++;
        end
        chk("after_lat", 64'(lat), 64'd2);
        chk("after_hi", 64'(hi8), 64'h10);
        chk("after_er", 64'(er8), 64'h01);
        @(posedge clk_sys); #1;

        // 40-bit instance: reset in the middle of a multiply
        run40(OP_ADD, 40'h40_0000_0000, 40'h10_0000_0000, 8'h01, lat);
        chk("w40_add_hi", 64'(hi40), 64'h50_0000_0000);
        chk("w40_add_er", 64'(er40), 64'h01);
        @(posedge clk_sys); #1;
        s40 = 1'b1; op40 = OP_MUL; a40 = 40'h40_0000_0000; b40 = 40'h20_0000_0000; ea40 = 8'h03;
        @(posedge clk_sys); #1;
        s40 = 1'b0;
        repeat (19) @(posedge clk_sys);
        #1;
        chk("w40_mid_busy", 64'({busy40, done40}), 64'b10);
        clr40 = 1'b0;
        #1;
        chk("w40_rst_busy", 64'({busy40, done40}), 64'b00);
        chk("w40_rst_hi", 64'(hi40), 64'h0);
        chk("w40_rst_lo", 64'(lo40), 64'h0);
        chk("w40_rst_er", 64'({er40, z40, v40}), 64'h0);
        clr40 = 1'b1;
        @(posedge clk_sys); #1;
        run40(OP_ADD, 40'h40_0000_0000, 40'h10_0000_0000, 8'h00, lat);
        chk("w40_re_lat", 64'(lat), 64'd2);
        chk("w40_re_hi", 64'(hi40), 64'h50_0000_0000);
        chk("w40_re_lo", 64'(lo40), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fpa_mant_engine.md
Name: fpa_mant_engine

Overview:
- Parametrised successor to the FPU mantissa datapath (F-PA).
- Autonomously sequences signed two's-complement fractional mantissa operations over a start/busy/done handshake: add, subtract, normalize and Booth radix-2 multiply.
- The microcode does not step individual shifts.
- Sits between the FPU control sequencer and the exponent logic.
- Mantissa width and exponent width are generic.

Parameters:
MW, 40, mantissa width in bits; bit 0 is the sign, MSB-first [0:MW-1]; MW >= 8.
EW, 8, exponent width; signed two's complement.

Ports:
clk_sys  in  1  system clock, rising edge.
clr_  in  1  asynchronous active-low reset.
start  in  1  request; sampled only in IDLE.
op  in  2  00 ADD, 01 SUB, 10 NORM, 11 MUL; sampled with start.
a  in  MW  operand A mantissa.
b  in  MW  operand B mantissa (ignored for NORM).
ea  in  EW  operand exponent.
busy  out  1  high in every non-IDLE state.
done  out  1  one-cycle pulse; results valid.
r_hi  out  MW  result mantissa, high part.
r_lo  out  MW  low product part; 0 for non-MUL ops.
er  out  EW  result exponent.
z  out  1  result zero: r_hi == 0 and r_lo == 0.
v  out  1  exponent overflow/underflow, or MUL saturation.

Behaviour:
- Reset (clr_ low, asynchronous, any state including mid-operation):
  - state IDLE.
  - All internal registers (T accumulator MW+1 bits, M MW bits, m[-1], C operand, shift counter, exponent) cleared.
  - Outputs: busy=0, done=0, r_hi=0, r_lo=0, er=0, z=0, v=0.
- States: IDLE, EXEC, NORM, MUL, DONE.
- IDLE + start=1: latch op, a→T, b→C (MUL: b→M, a→C, T=0, m[-1]=0), ea→exponent, counter=0; then go EXEC, except MUL goes directly to MUL. busy rises on that edge.
- start while busy is ignored; it is not queued.
- Latency L = rising edges from the start-sampling edge to the edge that raises done:
  - ADD/SUB: L=2.
  - NORM: L=2+k, where k = shifts performed.
  - MUL: L=MW+1.
- DONE lasts exactly one cycle with done=1, then IDLE.
- r_hi, r_lo, er, z and v update on the edge entering DONE. They hold until the next result is written; a new start does not clear them.
- ADD/SUB (EXEC):
  - Compute a±b on MW+1 bits.
  - No signed overflow: r_hi = sum, er = ea.
  - Signed overflow: r_hi = sum arithmetically shifted right 1 with the true sign (carry) in bit 0, er = ea+1.
  - If ea = max positive on overflow: er saturates at max, v=1.
- NORM:
  - EXEC: if a == 0 → DONE with r_hi=0, er=0, z=1, k=0.
  - Otherwise each NORM cycle: if t0 == t1, shift T left 1 (zero fill) and decrement the exponent; else → DONE.
  - Shifting is bounded at MW-1 shifts.
  - Shift needed with exponent = min negative → DONE with r_hi=0, er=0, z=1, v=1 (underflow).
  - Value -1.0 (1000…0) is already normalized: k=0.
- MUL (Booth radix-2, MW iterations, one per cycle):
  - Examine {M[MW-1], m[-1]}: 01 → T += C; 10 → T −= C; 00/11 → no add.
  - Then arithmetic shift right of {T, M, m[-1]} by 1.
  - After MW iterations → DONE.
  - Result = 2·(a·b) as a 2MW fraction: r_hi:r_lo = {T[MW-1:0], M} shifted left 1, with the T sign/extension bits consistent.
  - a = b = -1.0: saturate r_hi = 0111…1, r_lo = all ones, v=1.
  - er = ea.
- z is derived from the written r_hi/r_lo.
- v is cleared on every DONE where no overflow/underflow/saturation occurs.
- Exponent arithmetic is EW-bit signed. No other exponent wrap is permitted (saturate and flag instead).

Test Plan:
- Reset mid-MUL (MW=40, op=11, clr_ low at iteration 20) → busy=0, done=0, r_hi=r_lo=0, er=0 immediately; a subsequent ADD 0x4000000000+0x1000000000 gives r_hi=0x5000000000 with L=2.
- MW=8 ADD a=0x40, b=0x40, ea=3 → r_hi=0x40, er=4, v=0, done on edge 2. Same with ea=0x7F → er=0x7F, v=1.
- MW=8 NORM a=0x03, ea=0 → r_hi=0x60, er=-5 (0xFB), k=5, done on edge 7. NORM a=0 → r_hi=0, z=1, L=2. NORM a=0x01, ea=0x81 → underflow: z=1, v=1, er=0.
- MW=8 MUL a=0x40 (0.5), b=0xC0 (-0.5) → r_hi=0xE0, r_lo=0x00 (-0.25), L=9. MUL a=b=0x80 → r_hi=0x7F, r_lo=0xFF, v=1.
- Handshake: start held high through a MUL → no second operation until IDLE; start pulsed on the done cycle is ignored; start on the cycle after done is accepted. busy is never high together with done low in IDLE.
- SUB MW=8 a=0x80, b=0x01 → overflow: r_hi=0xBF, er=ea+1. Then SUB a=0x10, b=0x10 → r_hi=0, z=1.
